// File: rtl/rsa_mont_const.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rsa_mont_const
//
// Montgomery constant generator: computes const_out = 2^(2*WIDTH) mod p
// (R^2 mod P with R = 2^WIDTH) by 2*WIDTH shift-and-conditional-subtract
// steps starting from r = 1. Sits between the P register and the RSA unit's
// Const input.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   ena        clock enable; when low every register holds (a pending done too)
//   start      request; sampled only in IDLE with ena=1
//   p          modulus, sampled on the accepting edge
//   busy       computation in progress
//   done       one-enabled-cycle completion strobe (success or error)
//   err        last request had an even modulus or a modulus <= 1
//   const_out  R^2 mod p, meaningful only while valid=1
//   valid      const_out holds the result for the last accepted p
//
// Request protocol: start is a level sampled on an enabled edge while the FSM
// is idle; there is no ready, and starts seen while busy (including the
// completing edge) are dropped, not queued. done pulses for one enabled cycle;
// consumers qualify it with ena. A new start may be issued in the done cycle.
// ---------------------------------------------------------------------------
module rsa_mont_const #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] const_out,
    output logic             valid
);

    localparam int ITERS = 2 * WIDTH;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    cnt;
    // An invalid modulus is reported one edge after it is seen, so the error
    // done lands in the cycle after edge k+1 while the FSM stays idle.
    logic             bad_pend;

    logic             p_ok;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   p_ext;
    logic [WIDTH:0]   r_step;

    // Odd and not 1 is the same as odd and >= 3.
    assign p_ok = p[0] && (p != WIDTH'(1));

    // r < p_q always holds, so 2r < 2*p_q and a single subtraction keeps the
    // result below p_q; t needs one extra bit to hold 2r.
    always_comb begin
        t      = {r, 1'b0};
        p_ext  = {1'b0, p_q};
        r_step = t;
        if (t >= p_ext) begin
            r_step = t - p_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            p_q       <= '0;
            r         <= '0;
            cnt       <= '0;
            bad_pend  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            valid     <= 1'b0;
            const_out <= '0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bad_pend) begin
                        bad_pend  <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        valid     <= 1'b0;
                        const_out <= '0;
                    end else if (start) begin
                        if (p_ok) begin
                            p_q   <= p;
                            r     <= WIDTH'(1);
                            cnt   <= '0;
                            valid <= 1'b0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= ITER;
                        end else begin
                            bad_pend <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    r   <= r_step[WIDTH-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        const_out <= r_step[WIDTH-1:0];
                        valid     <= 1'b1;
                        done      <= 1'b1;
                        err       <= 1'b0;
                        busy      <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_mont_const.sv
`timescale 1ns/1ps
module tb_rsa_mont_const;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         ena;
    logic         start;
    logic [W-1:0] p;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] const_out;
    logic         valid;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    rsa_mont_const #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .p         (p),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .const_out (const_out),
        .valid     (valid)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it; all sampling and driving
    // happen at this point, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // ---------------- drivers ----------------
    // Issue a valid request now (so it may fall in a done cycle) and follow
    // it to completion, checking latency, busy width and the result.
    task automatic run_valid(input logic [W-1:0] pv);
        int lat;
        int busy_cnt;
        logic [W-1:0] expv;
        exp_q.push_back(W'(32'd65536 % {24'd0, pv}));
        p     = pv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("acc_busy", busy, 1);
        check("acc_valid_clr", valid, 0);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        expv = exp_q.pop_front();
        check("latency", lat, 16);
        check("busy_cycles", busy_cnt, 16);
        check("busy_at_done", busy, 0);
        check("valid", valid, 1);
        check("err", err, 0);
        check("const_out", const_out, expv);
    endtask

    task automatic run_invalid(input logic [W-1:0] pv);
        p     = pv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("inv_done_early", done, 0);
        check("inv_busy0", busy, 0);
        tick();
        check("inv_done", done, 1);
        check("inv_err", err, 1);
        check("inv_valid", valid, 0);
        check("inv_const", const_out, 0);
        check("inv_busy1", busy, 0);
        tick();
        check("inv_done_clr", done, 0);
        check("inv_err_hold", err, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int ndone;
        logic [W-1:0] rp;
        rst   = 1'b0;
        ena   = 1'b1;
        start = 1'b0;
        p     = '0;
        do_reset();

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", valid, 0);
        check("rst_const", const_out, 0);

        // Hand-computed: 65536 mod 251 = 25, mod 13 = 3, mod 255 = 1, mod 3 = 1.
        // Consecutive calls also exercise start in the done cycle.
        run_valid(8'd251);
        check("c251", const_out, 25);
        run_valid(8'd13);
        check("c13", const_out, 3);
        run_valid(8'd255);
        check("c255", const_out, 1);
        run_valid(8'd3);
        check("c3", const_out, 1);

        tick();
        run_invalid(8'd200);
        run_invalid(8'd1);

        // Start during ITER is ignored, as is a p change.
        p     = 8'd251;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        repeat (4) begin tick(); lat++; end
        p     = 8'd13;
        start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        while (!done && lat < 100) begin tick(); lat++; end
        check("ign_latency", lat, 16);
        check("ign_const", const_out, 25);
        ndone = 0;
        repeat (20) begin tick(); if (done) ndone++; end
        check("ign_no_second_done", ndone, 0);

        // Clock enable pause of 7 cycles mid-run stretches latency to 23.
        p     = 8'd251;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        repeat (3) begin tick(); lat++; end
        ena = 1'b0;
        repeat (7) begin tick(); lat++; end
        check("ena_busy_hold", busy, 1);
        ena = 1'b1;
        while (!done && lat < 100) begin tick(); lat++; end
        check("ena_latency", lat, 23);
        check("ena_const", const_out, 25);
        ena = 1'b0;
        tick();
        tick();
        check("ena_done_frozen", done, 1);
        ena = 1'b1;
        tick();
        check("ena_done_clr", done, 0);

        // Reset mid-run: everything back to zero, no done strobe.
        p     = 8'd13;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_err", err, 0);
        check("mrst_valid", valid, 0);
        check("mrst_const", const_out, 0);
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin tick(); if (done) ndone++; end
        check("mrst_no_done", ndone, 0);

        // Random odd moduli in [3,255].
        for (int i = 0; i < 500; i++) begin
            rp = W'($urandom_range(1, 127) * 2 + 1);
            run_valid(rp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
